dcp_dump: RTL and testbench

Debug command processor for the serial debug unit that dumps a block of consecutive register-file/memory words per command. On selection it scans a start address from the receiver, or continues from where the previous dump ended. For each of `WORDS` words it prints `<cmd><addr>=<data>\r\n` through the transmitter, then raises `finish`. It is a parametrised successor of the single-word read processor and sits beside the other DCP blocks under the command dispatcher (`sel_mode`).

---
 rtl/dcp_dump_if.sv | 25 ++
 rtl/dcp_dump.sv | 189 ++++++++++++++++++
 tb/tb_dcp_dump.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dcp_dump_if.sv
// Handshake bundle between a DCP command block and the serial debug unit:
// one scan channel (receiver) and one print channel (transmitter).
interface dcp_dump_if;
  logic        req_rx;
  logic        type_rx;
  logic [31:0] din_rx;
  logic        flag_rx;
  logic        ack_rx;
  logic        req_tx;
  logic        type_tx;
  logic [31:0] dout;
  logic        ack_tx;

  // Command block side: issues requests, consumes scanned values.
  modport master (
    output req_rx, type_rx, req_tx, type_tx, dout,
    input  din_rx, flag_rx, ack_rx, ack_tx
  );

  // Serial unit side: answers requests.
  modport slave (
    input  req_rx, type_rx, req_tx, type_tx, dout,
    output din_rx, flag_rx, ack_rx, ack_tx
  );
endinterface

// File: rtl/dcp_dump.sv
// Debug command processor: dumps WORDS consecutive array words per command
// as "<cmd><addr>=<data>\r\n" lines. The start address is scanned, or an
// empty line resumes after the last fully printed word.
// DATA_W must be <= 32 and WORDS >= 1.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | not selected; outputs and counters cleared
// SCAN  | raise scan request for the start address
// WAITS | wait for scan acknowledge, latch start address
// LOAD  | capture array data at cur_addr
// SEND  | present one field of the line and raise print request
// WAITT | wait for print acknowledge, advance field
// NEXT  | line complete; advance address and word count
// DONE  | all words printed; finish held until deselected
module dcp_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        sel_mode,
  input  logic [7:0]        cmd_code,
  output logic              finish,
  dcp_dump_if.master        bus,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din_rf
);

  localparam int WC_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_WAITS = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;
  localparam logic [2:0] S_WAITT = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [2:0] FLD_LAST = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              finish_q, finish_d;
  logic              req_rx_q, req_rx_d;
  logic              type_rx_q, type_rx_d;
  logic              req_tx_q, req_tx_d;
  logic              type_tx_q, type_tx_d;
  logic [31:0]       dout_q, dout_d;
  logic [2:0]        fld_q, fld_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              active;
  logic [ADDR_W-1:0] addr_inc;
  logic              unused_din_rx;

  assign active        = (sel_mode == cmd_code);
  assign addr_inc      = cur_addr_q + ADDR_W'(1);
  assign unused_din_rx = ^bus.din_rx;

  // Next-state and datapath updates for the dump sequencer.
  always_comb begin
    state_d     = state_q;
    finish_d    = finish_q;
    req_rx_d    = req_rx_q;
    type_rx_d   = type_rx_q;
    req_tx_d    = req_tx_q;
    type_tx_d   = type_tx_q;
    dout_d      = dout_q;
    fld_d       = fld_q;
    wcnt_d      = wcnt_q;
    cur_addr_d  = cur_addr_q;
    last_addr_d = last_addr_q;
    data_d      = data_q;

    if (!active || (state_q == S_IDLE)) begin
      // Deselect drops everything on the same edge, so a request never
      // lingers into IDLE and a coincident ack cannot advance last_addr.
      finish_d  = 1'b0;
      req_rx_d  = 1'b0;
      type_rx_d = 1'b0;
      req_tx_d  = 1'b0;
      type_tx_d = 1'b0;
      dout_d    = '0;
      fld_d     = '0;
      wcnt_d    = '0;
      state_d   = active ? S_SCAN : S_IDLE;
    end else begin
      case (state_q)
        S_SCAN: begin
          req_rx_d  = 1'b1;
          type_rx_d = 1'b1;
          state_d   = S_WAITS;
        end
        S_WAITS: begin
          if (bus.ack_rx) begin
            req_rx_d   = 1'b0;
            cur_addr_d = bus.flag_rx ? last_addr_q : bus.din_rx[ADDR_W-1:0];
            state_d    = S_LOAD;
          end
        end
        S_LOAD: begin
          data_d  = din_rf;
          state_d = S_SEND;
        end
        S_SEND: begin
          req_tx_d = 1'b1;
          case (fld_q)
            3'd0: begin type_tx_d = 1'b0; dout_d = {24'h0, cmd_code}; end
            3'd1: begin type_tx_d = 1'b1; dout_d = 32'(cur_addr_q);    end
            3'd2: begin type_tx_d = 1'b0; dout_d = 32'h0000_003D;      end
            3'd3: begin type_tx_d = 1'b1; dout_d = 32'(data_q);        end
            3'd4: begin type_tx_d = 1'b0; dout_d = 32'h0000_000D;      end
            default: begin type_tx_d = 1'b0; dout_d = 32'h0000_000A;   end
          endcase
          state_d = S_WAITT;
        end
        S_WAITT: begin
          if (bus.ack_tx) begin
            req_tx_d = 1'b0;
            if (fld_q == FLD_LAST) begin
              fld_d   = '0;
              state_d = S_NEXT;
            end else begin
              fld_d   = fld_q + 3'd1;
              state_d = S_SEND;
            end
          end
        end
        S_NEXT: begin
          // last_addr only moves once a whole line is out, so an aborted
          // dump resumes at the first incomplete word.
          cur_addr_d  = addr_inc;
          last_addr_d = addr_inc;
          wcnt_d      = wcnt_q + WC_W'(1);
          state_d     = (wcnt_q == WC_W'(WORDS - 1)) ? S_DONE : S_LOAD;
        end
        S_DONE: begin
          finish_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      finish_q    <= 1'b0;
      req_rx_q    <= 1'b0;
      type_rx_q   <= 1'b0;
      req_tx_q    <= 1'b0;
      type_tx_q   <= 1'b0;
      dout_q      <= '0;
      fld_q       <= '0;
      wcnt_q      <= '0;
      cur_addr_q  <= '0;
      last_addr_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      finish_q    <= finish_d;
      req_rx_q    <= req_rx_d;
      type_rx_q   <= type_rx_d;
      req_tx_q    <= req_tx_d;
      type_tx_q   <= type_tx_d;
      dout_q      <= dout_d;
      fld_q       <= fld_d;
      wcnt_q      <= wcnt_d;
      cur_addr_q  <= cur_addr_d;
      last_addr_q <= last_addr_d;
      data_q      <= data_d;
    end
  end

  assign finish      = finish_q;
  assign bus.req_rx  = req_rx_q;
  assign bus.type_rx = type_rx_q;
  assign bus.req_tx  = req_tx_q;
  assign bus.type_tx = type_tx_q;
  assign bus.dout    = dout_q;
  assign addr        = cur_addr_q;

endmodule

// File: tb/tb_dcp_dump.sv
// Directed bench for dcp_dump: expected print fields are queued when a
// command is issued and popped as each transmit request is acknowledged.
module tb_dcp_dump;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;
  localparam logic [7:0] CMD = 8'h52;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [7:0]        sel_mode = 8'h00;
  logic              finish;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din_rf;

  dcp_dump_if bus_if ();

  dcp_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sel_mode (sel_mode),
    .cmd_code (CMD),
    .finish   (finish),
    .bus      (bus_if),
    .addr     (addr),
    .din_rf   (din_rf)
  );

  always #5 clk = ~clk;

  // Array model: word at a holds a * 0x11111111.
  assign din_rf = 32'(addr) * 32'h1111_1111;

  int n_assert = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [ADDR_W-1:0] tb_last = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [ADDR_W-1:0] a);
    logic [31:0] d;
    d = 32'(a) * 32'h1111_1111;
    exp_q.push_back({1'b0, 24'h0, CMD});
    exp_q.push_back({1'b1, 32'(a)});
    exp_q.push_back({1'b0, 32'h3D});
    exp_q.push_back({1'b1, d});
    exp_q.push_back({1'b0, 32'h0D});
    exp_q.push_back({1'b0, 32'h0A});
  endtask

  // Run one command; abort_after>0 deselects together with that tx ack.
  task automatic do_cmd(input logic [31:0] scan, input logic flag,
                        input int max_delay, input int abort_after,
                        input bit check_lat);
    logic [ADDR_W-1:0] start;
    logic [32:0] held, e;
    bit   done, aborted, prev_req, acked_prev, rx_done;
    int   ntx, delay, rx_c, abort_wait;
    start = flag ? tb_last : scan[ADDR_W-1:0];
    for (int w = 0; w < WORDS; w++) push_word(start + ADDR_W'(w));
    done = 0; aborted = 0; prev_req = 0; acked_prev = 0; rx_done = 0;
    ntx = 0; delay = 0; rx_c = 0; abort_wait = 0; held = '0;
    @(negedge clk);
    sel_mode = CMD;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      bus_if.ack_rx = 1'b0;
      bus_if.ack_tx = 1'b0;
      if (aborted) begin
        abort_wait--;
        if (abort_wait == 0) begin
          chk("abort_req_tx", bus_if.req_tx, 0);
          chk("abort_req_rx", bus_if.req_rx, 0);
          chk("abort_finish", finish, 0);
          done = 1;
        end
        continue;
      end
      if (acked_prev) chk("req_tx_fall", bus_if.req_tx, 0);
      acked_prev = 0;
      if (bus_if.req_rx && !rx_done) begin
        if (check_lat) chk("rx_latency_edges", c + 1, 2);
        chk("type_rx", bus_if.type_rx, 1);
        bus_if.ack_rx  = 1'b1;
        bus_if.din_rx  = scan;
        bus_if.flag_rx = flag;
        rx_done = 1;
        rx_c = c;
      end
      if (bus_if.req_tx) begin
        if (prev_req) begin
          chk("tx_stable", {bus_if.type_tx, bus_if.dout}, held);
        end else begin
          held = {bus_if.type_tx, bus_if.dout};
          delay = (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
          if (check_lat && ntx == 0) chk("tx_latency", c - rx_c, 3);
        end
        if (delay == 0) begin
          e = exp_q.pop_front();
          chk("tx_field", {bus_if.type_tx, bus_if.dout}, e);
          bus_if.ack_tx = 1'b1;
          ntx++;
          acked_prev = 1;
          if (ntx == abort_after) begin
            sel_mode = 8'h00;
            aborted = 1;
            abort_wait = 2;
          end
        end else begin
          delay--;
        end
      end else if (max_delay > 0 && $urandom_range(3, 0) == 0) begin
        bus_if.ack_tx = 1'b1;  // stray ack while no request is pending
      end
      prev_req = bus_if.req_tx && !acked_prev;
      if (finish && !aborted) begin
        chk("tx_count", ntx, WORDS * 6);
        chk("queue_empty", exp_q.size(), 0);
        done = 1;
      end
    end
    chk("cmd_in_budget", done, 1);
    tb_last = start + ADDR_W'(aborted ? ntx / 6 : WORDS);
    exp_q.delete();
    bus_if.ack_tx = 1'b0;
    sel_mode = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("idle_finish", finish, 0);
    chk("idle_req_tx", bus_if.req_tx, 0);
  endtask

  initial begin
    bit got_rx;
    bus_if.ack_rx  = 1'b0;
    bus_if.ack_tx  = 1'b0;
    bus_if.din_rx  = '0;
    bus_if.flag_rx = 1'b0;
    #12;
    chk("rst_finish", finish, 0);
    chk("rst_req_rx", bus_if.req_rx, 0);
    chk("rst_req_tx", bus_if.req_tx, 0);
    chk("rst_dout", bus_if.dout, 0);
    chk("rst_addr", addr, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    do_cmd(32'h3, 1'b0, 0, 0, 1);        // 3..6
    do_cmd(32'h0, 1'b1, 0, 0, 0);        // resume at 7
    do_cmd(32'h1E, 1'b0, 0, 0, 0);       // wrap 1E,1F,0,1
    do_cmd(32'h0, 1'b1, 5, 0, 0);        // random ack delays from 2
    do_cmd(32'h10, 1'b0, 0, 9, 0);       // abort inside word 2
    do_cmd(32'h0, 1'b1, 0, 0, 0);        // resume at 0x11

    // Reset while waiting for the scan acknowledge.
    @(negedge clk);
    sel_mode = CMD;
    got_rx = 0;
    for (int c = 0; c < 20 && !got_rx; c++) begin
      @(negedge clk);
      got_rx = bus_if.req_rx;
    end
    chk("reset_test_saw_req_rx", got_rx, 1);
    @(negedge clk);
    rstn = 1'b0;
    sel_mode = 8'h00;
    #1;
    chk("midrst_req_rx", bus_if.req_rx, 0);
    chk("midrst_type_rx", bus_if.type_rx, 0);
    chk("midrst_req_tx", bus_if.req_tx, 0);
    chk("midrst_dout", bus_if.dout, 0);
    chk("midrst_addr", addr, 0);
    tb_last = '0;
    @(negedge clk);
    rstn = 1'b1;
    do_cmd(32'h0, 1'b1, 0, 0, 0);        // dumps from 0

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
